// File: rtl/morse_collect_symbols.sv
// Collects timed key marks into Morse elements and emits one code per character,
// plus error on overlong characters and a pulse on each inter-word gap.
`ifndef MAX_MORSE_LEN
`define MAX_MORSE_LEN 5
`endif
`ifndef MORSE_LEN_W
`define MORSE_LEN_W 3
`endif

module morse_collect_symbols #(
  parameter int TICKS_PER_UNIT = 5_000_000,
  parameter int DAH_UNITS      = 2,
  parameter int CHAR_GAP_UNITS = 2,
  parameter int WORD_GAP_UNITS = 5
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      key,
  output logic [`MORSE_LEN_W-1:0]   len,
  output logic [`MAX_MORSE_LEN-1:0] dits_dahs,
  output logic                      valid,
  output logic                      error,
  output logic                      space_valid
);
  localparam int ML      = `MAX_MORSE_LEN;
  localparam int CNT_W   = `MORSE_LEN_W;
  localparam int PRE_W   = $clog2(TICKS_PER_UNIT);
  localparam int UNITS_W = $clog2(WORD_GAP_UNITS + 1);

  typedef enum logic [1:0] {IDLE, MARK, SPACE} state_t;

  state_t             state, state_nxt;
  logic [ML-1:0]      sh;
  logic [CNT_W-1:0]   cnt;
  logic               ovf, emt;
  logic [PRE_W-1:0]   pre;
  logic [UNITS_W-1:0] units;
  logic               classify, emit, word_end, pre_wrap, dah;

  assign pre_wrap = (pre == PRE_W'(TICKS_PER_UNIT - 1));
  assign dah      = (units >= UNITS_W'(DAH_UNITS));

  always_comb begin
    state_nxt = state;
    classify  = 1'b0;
    emit      = 1'b0;
    word_end  = 1'b0;
    case (state)
      IDLE:  if (key) state_nxt = MARK;
      MARK:  if (!key) begin
               state_nxt = SPACE;
               classify  = 1'b1;
             end
      SPACE: begin
        // char-gap emission is independent of a simultaneous key press
        emit = (units == UNITS_W'(CHAR_GAP_UNITS)) && !emt;
        if (key) state_nxt = MARK;
        else if ((units == UNITS_W'(WORD_GAP_UNITS)) && emt) begin
          word_end  = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      sh          <= '0;
      cnt         <= '0;
      ovf         <= 1'b0;
      emt         <= 1'b0;
      pre         <= '0;
      units       <= '0;
      len         <= '0;
      dits_dahs   <= '0;
      valid       <= 1'b0;
      error       <= 1'b0;
      space_valid <= 1'b0;
    end else begin
      state       <= state_nxt;
      valid       <= 1'b0;
      error       <= 1'b0;
      space_valid <= 1'b0;

      if (state_nxt != state) begin
        pre   <= '0;
        units <= '0;
      end else if (pre_wrap) begin
        pre <= '0;
        if (units != UNITS_W'(WORD_GAP_UNITS)) units <= units + 1'b1;
      end else begin
        pre <= pre + 1'b1;
      end

      if (classify) begin
        if (cnt < CNT_W'(ML)) begin
          sh  <= {sh[ML-2:0], dah};
          cnt <= cnt + 1'b1;
        end else begin
          ovf <= 1'b1;
        end
      end

      if (emit) begin
        if (ovf) error <= 1'b1;
        else begin
          valid     <= 1'b1;
          len       <= cnt;
          dits_dahs <= sh;
        end
        sh  <= '0;
        cnt <= '0;
        ovf <= 1'b0;
        emt <= 1'b1;
      end

      if (word_end) begin
        space_valid <= 1'b1;
        emt         <= 1'b0;
      end

      // a new mark re-arms emission and cancels the pending word gap
      if (state == SPACE && key) emt <= 1'b0;
    end
  end

endmodule

// File: doc/morse_collect_symbols.md
MORSE_COLLECT_SYMBOLS -- requirements
Module: MORSE_COLLECT_SYMBOLS

Interface
REQ-001 Parameter TICKS_PER_UNIT, default 5_000_000, sets clk cycles per Morse time unit (100 ms at 50 MHz); legal range >= 2.
REQ-002 Parameter DAH_UNITS, default 2, sets the mark length in units at or above which an element is a dah.
REQ-003 Parameter CHAR_GAP_UNITS, default 2, sets the space length in units that ends a character.
REQ-004 Parameter WORD_GAP_UNITS, default 5, sets the space length in units that ends a word; it SHALL be greater than CHAR_GAP_UNITS.
REQ-005 clk  input  1  single system clock; all logic is on the rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 key  input  1  key level, 1 = pressed; already synchronized and debounced to clk upstream.
REQ-008 len  output  `MORSE_LEN_W  element count of the last emitted character.
REQ-009 dits_dahs  output  `MAX_MORSE_LEN  elements of the last emitted character: first element in bit len-1, last element in bit 0, 1 = dah, 0 = dit, unused upper bits 0.
REQ-010 valid  output  1  one-cycle pulse; len/dits_dahs hold a new character.
REQ-011 error  output  1  one-cycle pulse; a character with more than `MAX_MORSE_LEN elements was discarded.
REQ-012 space_valid  output  1  one-cycle pulse; word gap detected.

Function
REQ-013 The block SHALL implement states IDLE, MARK and SPACE, plus an internal shift register sh, count cnt, overflow flag ovf, emitted flag emt, prescaler pre and unit counter units.
REQ-014 pre SHALL count 0..TICKS_PER_UNIT-1 and wrap; on each wrap units SHALL increment, saturating at WORD_GAP_UNITS.
REQ-015 Every state transition SHALL clear pre and units to 0.
REQ-016 IDLE: key=1 -> MARK; otherwise stay.
REQ-017 MARK: key=0 -> SPACE, and in that cycle the element SHALL be classified: dah if units >= DAH_UNITS, else dit.
REQ-018 On classification with cnt < `MAX_MORSE_LEN, sh SHALL become {sh[`MAX_MORSE_LEN-2:0], element} and cnt SHALL increment; with cnt = `MAX_MORSE_LEN, sh/cnt SHALL be unchanged and ovf SHALL be set.
REQ-019 SPACE, first cycle with units = CHAR_GAP_UNITS and emt=0: if ovf=0, len<=cnt, dits_dahs<=sh and valid pulses on the next cycle; if ovf=1, error pulses instead and len/dits_dahs are unchanged. In both cases sh, cnt and ovf SHALL clear and emt SHALL set.
REQ-020 SPACE with units = WORD_GAP_UNITS and emt=1: space_valid SHALL pulse on the next cycle, emt SHALL clear, and the state SHALL go to IDLE.
REQ-021 SPACE with key=1 -> MARK; emt SHALL clear. If the REQ-019 condition holds in the same cycle, emission SHALL still occur, and the new element SHALL start from cleared sh/cnt/ovf. No space_valid SHALL be produced.
REQ-022 In MARK, units SHALL saturate, so an arbitrarily long press is a single dah with no output pulse.
REQ-023 valid, error and space_valid SHALL be registered, mutually exclusive, and never high for two consecutive cycles from a single event.
REQ-024 len/dits_dahs SHALL change only in the cycle before valid and SHALL hold otherwise, so the downstream recognizer sees a stable code.
REQ-025 A key press in IDLE SHALL never produce space_valid; at most one space_valid per word.

Reset
REQ-026 While reset=1 at a clk edge: state=IDLE; sh, cnt, ovf, emt, pre and units = 0; len = 0, dits_dahs = 0, valid = 0, error = 0, space_valid = 0.
REQ-027 Reset mid-MARK or mid-SPACE SHALL discard the partial character with no pulse; after reset the block SHALL be idle, with key sampled from the first cycle after deassertion.

Verification (TICKS_PER_UNIT=4, DAH_UNITS=2, CHAR_GAP_UNITS=2, WORD_GAP_UNITS=5; dit = key high 4 clk, dah = key high 12 clk)
REQ-028 Reset held 3 cycles with key toggling -> all outputs 0; no pulses for 40 clk with key=0.
REQ-029 One dit, then key low -> exactly one valid pulse about 9 clk after release; len=1, dits_dahs=5'b00000 (E); then one space_valid about 21 clk after release.
REQ-030 Dit, 4 clk gap, dah, then key low -> valid with len=2, dits_dahs=5'b00001 (A); repeat with dah,dit,dit -> len=3, dits_dahs=5'b00100 (D).
REQ-031 Six dits with 4 clk gaps -> one error pulse, no valid, len/dits_dahs keep the previous values; a following dit gives valid with len=1.
REQ-032 After E is emitted, press the key 12 clk after release (before the word gap) -> no space_valid; a key press exactly on the char-gap cycle -> valid still pulses and the new element is counted as element 1.
REQ-033 Reset asserted in the middle of the third element of a dah-dah-dah sequence -> no valid/error; the next single dah gives len=1, dits_dahs=5'b00001.
